// File: rtl/reg_sched_pkg.sv
// Shared types for the register-file write scheduler.
// Widths, register-zero constant, writeback request bundle, hold states.
package reg_sched_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/wb_skid_buffer.sv
// One-entry hold register for an MDU result that lost the write port.
// Ports: cap_i (capture request), drain_i, hold_o (held entry), ready_o.
module wb_skid_buffer
  import reg_sched_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  wb_req_t cap_i,
  input  logic    drain_i,
  output wb_req_t hold_o,
  output logic    ready_o
);

  hold_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      HOLD_EMPTY: begin
        if (cap_i.valid) begin
          state_d = HOLD_FULL;
          addr_d  = cap_i.addr;
          data_d  = cap_i.data;
        end
      end
      HOLD_FULL: begin
        if (drain_i) begin
          state_d = HOLD_EMPTY;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= HOLD_EMPTY;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign hold_o  = '{valid: (state_q == HOLD_FULL),
                     addr:  addr_q,
                     data:  data_q};
  assign ready_o = (state_q == HOLD_EMPTY);

endmodule

// File: rtl/reg_write_scheduler.sv
// Merges ALU and MDU writebacks onto one RF write port, tracks pending MDU
// dests, stalls decode on hazards/starvation. Ports: issue_*, wb_*, rf_*, busy.
module reg_write_scheduler #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rs,
  input  logic [ADDR_WIDTH-1:0] issue_rt,
  input  logic                  issue_uses_rs,
  input  logic                  issue_uses_rt,
  input  logic [ADDR_WIDTH-1:0] issue_dest,
  input  logic                  issue_long,
  output logic                  issue_stall,
  input  logic                  wb_alu_valid,
  input  logic [ADDR_WIDTH-1:0] wb_alu_addr,
  input  logic [DATA_WIDTH-1:0] wb_alu_data,
  input  logic                  wb_mdu_valid,
  input  logic [ADDR_WIDTH-1:0] wb_mdu_addr,
  input  logic [DATA_WIDTH-1:0] wb_mdu_data,
  output logic                  wb_mdu_ready,
  output logic                  rf_write_en,
  output logic [ADDR_WIDTH-1:0] rf_write_addr,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic                  busy
);

  import reg_sched_pkg::wb_req_t;
  import reg_sched_pkg::REG_ZERO;

  localparam int NREG = 1 << ADDR_WIDTH;
  localparam int CW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [NREG-1:0] pending_q, pending_d;
  logic [CW-1:0]   starve_cnt_q, starve_cnt_d;

  wb_req_t alu_req, mdu_req, hold_req, cap_req, wr_req;
  logic    hold_ready, mdu_acc, drain;
  logic    clr, hazard, starve, issue_set;
  logic [ADDR_WIDTH-1:0] clr_addr;

  assign alu_req = '{valid: wb_alu_valid,
                     addr:  wb_alu_addr,
                     data:  wb_alu_data};
  assign mdu_req = '{valid: wb_mdu_valid,
                     addr:  wb_mdu_addr,
                     data:  wb_mdu_data};

  assign wb_mdu_ready = !reset && hold_ready;
  assign mdu_acc      = wb_mdu_valid && wb_mdu_ready;

  wb_skid_buffer u_hold (
    .clock   (clock),
    .reset   (reset),
    .cap_i   (cap_req),
    .drain_i (drain),
    .hold_o  (hold_req),
    .ready_o (hold_ready)
  );

  // ALU > held MDU > direct MDU. While the hold is full ready is low,
  // so a direct MDU write and a drain never coincide.
  always_comb begin
    wr_req   = '0;
    cap_req  = '0;
    drain    = 1'b0;
    clr      = 1'b0;
    clr_addr = wb_mdu_addr;
    if (wb_alu_valid) begin
      wr_req        = alu_req;
      cap_req       = mdu_req;
      cap_req.valid = mdu_acc;
    end else if (hold_req.valid) begin
      wr_req   = hold_req;
      drain    = !reset;
      clr      = 1'b1;
      clr_addr = hold_req.addr;
    end else if (mdu_acc) begin
      wr_req = mdu_req;
      clr    = 1'b1;
    end
  end

  assign rf_write_en   = !reset && wr_req.valid &&
                         (wr_req.addr != REG_ZERO);
  assign rf_write_addr = wr_req.addr;
  assign rf_write_data = wr_req.data;

  // Registered pending only: a consumer issues the cycle after the write.
  assign hazard = (issue_uses_rs && pending_q[issue_rs]) ||
                  (issue_uses_rt && pending_q[issue_rt]) ||
                  (issue_long    && pending_q[issue_dest]);
  assign starve = (starve_cnt_q == LIMIT);

  assign issue_stall = issue_valid && (reset || hazard || starve);
  assign issue_set   = issue_valid && !issue_stall && issue_long &&
                       (issue_dest != REG_ZERO);

  // Set is applied after clear so a same-address set wins.
  always_comb begin
    pending_d = pending_q;
    if (clr) begin
      pending_d[clr_addr] = 1'b0;
    end
    if (issue_set) begin
      pending_d[issue_dest] = 1'b1;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (drain) begin
      starve_cnt_d = '0;
    end else if (hold_req.valid && wb_alu_valid && !starve) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q    <= '0;
      starve_cnt_q <= '0;
    end else begin
      pending_q    <= pending_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign busy = !reset && ((|pending_q) || hold_req.valid);

endmodule

// File: doc/reg_write_scheduler.md
# reg_write_scheduler

Shares the single register-file write port between the in-order pipeline writeback (ALU/load path) and the multi-cycle multiply/divide unit (MDU), and keeps a scoreboard of registers with outstanding MDU results. It sits between decode and the register file: decode presents each instruction's operands and receives a stall, and both writeback sources are merged onto one `rf_write_*` port. The ALU path always wins. A losing MDU result is parked in a one-entry hold buffer. A starvation counter forces decode to stall so that the parked result drains.

## Interface
Parameters:
- `DATA_WIDTH`, 32, register data width
- `ADDR_WIDTH`, 5, register address width (2^ADDR_WIDTH registers)
- `STARVE_LIMIT`, 4, number of consecutive blocked cycles of a held MDU result before issue is forced to stall

Ports:
- `clock`  in  1  single clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high
- `issue_valid`  in  1  decode presents an instruction
- `issue_rs`, `issue_rt`  in  ADDR_WIDTH  source registers
- `issue_uses_rs`, `issue_uses_rt`  in  1  source actually read
- `issue_dest`  in  ADDR_WIDTH  destination register
- `issue_long`  in  1  instruction goes to MDU and will write `issue_dest`
- `issue_stall`  out  1  decode must hold; the instruction is not issued
- `wb_alu_valid`  in  1  pipeline writeback request (cannot be back-pressured)
- `wb_alu_addr`  in  ADDR_WIDTH;  `wb_alu_data`  in  DATA_WIDTH
- `wb_mdu_valid`  in  1  MDU result available
- `wb_mdu_addr`  in  ADDR_WIDTH;  `wb_mdu_data`  in  DATA_WIDTH
- `wb_mdu_ready`  out  1  MDU result accepted when valid && ready
- `rf_write_en`  out  1;  `rf_write_addr`  out  ADDR_WIDTH;  `rf_write_data`  out  DATA_WIDTH  register-file write port
- `busy`  out  1  at least one MDU result outstanding (pending bit set or hold buffer valid)

## Operation
- **Scoreboard:** `pending[2^ADDR_WIDTH]`.
  - Set `pending[issue_dest]` on an issued long op: `issue_valid && !issue_stall && issue_long && issue_dest != 0`.
  - Clear `pending[a]` when the MDU result for `a` is written to the register file.
  - Same-cycle set and clear of the same address: set wins.
  - Register 0 is never marked pending.
- **Hazard stall:** `issue_stall = issue_valid && (hazard || starve)`.
  - `hazard` = (`issue_uses_rs` && `pending[rs]`) || (`issue_uses_rt` && `pending[rt]`) || (`issue_long` && `pending[dest]`), where the last term is the WAW check.
  - `hazard` is evaluated on registered `pending` only, with no same-cycle bypass of a clearing write. A consumer therefore issues one cycle after the producing write.
- **Port arbitration:** fixed priority, in order:
  1. `wb_alu_valid` writes ALU data.
  2. Otherwise, if the hold buffer is valid, write the held data and clear the hold.
  3. Otherwise, if `wb_mdu_valid`, write MDU data directly.
- **MDU handshake:**
  - `wb_mdu_ready = !hold_valid`.
  - An accepted MDU result that loses to the ALU path is captured into the hold buffer.
- **Register 0 writes:** any write addressed to register 0 forces `rf_write_en = 0`. The handshake and pending bookkeeping still complete.
- **Starvation counter:**
  - `starve_cnt` increments each cycle `hold_valid && wb_alu_valid`.
  - It resets to 0 when the hold drains.
  - It saturates at `STARVE_LIMIT`.
  - `starve = (starve_cnt == STARVE_LIMIT)`. This drains the pipeline until ALU writebacks stop and the held result commits.
- **Hold buffer states:** EMPTY → FULL on an accepted MDU result that loses arbitration. FULL → EMPTY on the first cycle with `!wb_alu_valid`.

## Timing
- Reset values:
  - `pending = 0`, `hold_valid = 0`, `starve_cnt = 0`.
  - While `reset` is high: `rf_write_en = 0`, `wb_mdu_ready = 0`, `issue_stall = 1` if `issue_valid`, `busy = 0`.
- `rf_write_*` are combinational from the inputs and the hold buffer, so the register file commits on the same posedge (0-cycle latency for a direct write).
- A held MDU result commits no earlier than the cycle after capture.
- A `pending` clear becomes visible to `issue_stall` one cycle after the write.
- Reset mid-operation: the hold contents are discarded and all pending bits are cleared. The MDU and pipeline are reset together.

## Structure
- Package `reg_sched_pkg`: `DATA_WIDTH`, `ADDR_WIDTH`, `REG_ZERO` constant, and a `wb_req_t` struct (valid, addr, data) used by both writeback sources and the hold buffer.
- Sub-module `wb_skid_buffer`: the one-entry hold register with valid/ready, data capture and drain. The top level holds the scoreboard, stall logic, arbiter mux and starvation counter.

## Test plan
- **Long-op RAW stall:** issue long op with dest=5, then an instruction reading rs=5. Required: `issue_stall=1` until MDU writes r5. The write appears as `rf_write_en=1`, `addr=5`, and stall drops the following cycle.
- **Collision:** `wb_alu_valid` (addr 3, data 0x11) and `wb_mdu_valid` (addr 7, data 0x22) in the same cycle. Required: r3=0x11 written that cycle and `wb_mdu_ready` then drops for one cycle. r7=0x22 is written the next cycle when there is no ALU write, after which `pending[7]` clears and ready returns to 1.
- **Starvation:** hold the buffer full while `wb_alu_valid=1` for 4 cycles. Required: `issue_stall=1` from the cycle `starve_cnt` reaches 4. Once ALU valid drops, the held write commits and `starve_cnt` returns to 0.
- **Register zero:** long op with dest=0 then an MDU result to r0. Required: no pending bit is set, `rf_write_en=0` and `wb_mdu_ready=1`.
- **WAW plus same-cycle set/clear:** issue a long op with dest=9 in the same cycle the MDU result for r9 commits. Required: `pending[9]` remains 1. Issuing a second long op with dest=9 while pending is set gives `issue_stall=1`.
- **Reset mid-operation:** with the hold full and pending={4,6}, assert reset for 1 cycle. Required: `busy=0`, `rf_write_en=0`, `wb_mdu_ready=1` after release, and no stale write to r4 or r6 appears.
